sel_input_debounce: RTL
=======================

# sel_input_debounce

Input conditioner directly upstream of the 4:1 two-bit selector. It synchronises the ten raw board switches into the clock domain and debounces each bit independently. It then presents the settled values as the selector's `ctrl`, `in0`..`in3` buses, so the selector sees only clean, glitch-free codes. It also reports which bits settled to a new value and when.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive cycles a synchronised bit must differ from its settled value before the settled value flips; legal range 2..65535.
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sw_in`  in  10  raw asynchronous switch levels.
- `sw_stable`  out  10  settled (debounced) switch levels.
- `changed_mask`  out  10  one-cycle mask of bits whose `sw_stable` value updated on the last edge.
- `changed`  out  1  OR of `changed_mask`.
- `ctrl`  out  2  `sw_stable[9:8]`, to the selector's select input.
- `in3`  out  2  `sw_stable[7:6]`.
- `in2`  out  2  `sw_stable[5:4]`.
- `in1`  out  2  `sw_stable[3:2]`.
- `in0`  out  2  `sw_stable[1:0]`.

## Operation
- Synchroniser: two flop stages per bit, `s1 <= sw_in`, `s2 <= s1`. Only `s2` is used downstream. The stages are not reset-bypassed; `rst` clears them to 0.
- Per-bit counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES)`, unsigned.
- Each edge, per bit i, not in reset:
  - `s2[i] == sw_stable[i]`: `cnt[i] <= 0`, no update.
  - Differs and `cnt[i] == DEBOUNCE_CYCLES-1`: `sw_stable[i] <= s2[i]`, `cnt[i] <= 0`, `changed_mask[i] <= 1`.
  - Differs otherwise: `cnt[i] <= cnt[i]+1`, `changed_mask[i] <= 0`.
- Counters never wrap. Any single cycle of agreement restarts the count from 0, so a bounce shorter than `DEBOUNCE_CYCLES` produces no output change.
- Bits are fully independent. Several bits may settle on the same edge, giving a multi-bit `changed_mask` and a single `changed` pulse.
- `ctrl`/`in*` are pure wiring of `sw_stable`, with no extra register.
- Reset values: `s1`, `s2`, `sw_stable`, `cnt`, `changed_mask` and `changed` are all 0, so `ctrl`, `in0`..`in3` are 0.
- Reset asserted mid-count discards all progress. After release, a switch held at 1 needs the full latency again before `sw_stable` goes to 1.
- `rst` has priority over every other update on the same edge.

## Timing
- Take edge E0 as the first edge at which the new `sw_in` level is sampled into `s1`.
  - `s2` shows the new level after E1.
  - Counting edges are E2..E(DEBOUNCE_CYCLES+1).
  - `sw_stable` and `changed_mask` update at E(DEBOUNCE_CYCLES+1).
- Latency from first sample to settled output is therefore `DEBOUNCE_CYCLES+2` edges. With the default of 16, that is 18 edges.
- `changed` and `changed_mask` are high for exactly the one cycle following the update edge. This is coincident with the first cycle in which the new `sw_stable` is visible.
- A level that toggles back before the settle edge leaves `sw_stable` unchanged and `changed` low throughout.
- There is no backpressure; the selector downstream is combinational and always accepts.

## Test plan
All scenarios use `DEBOUNCE_CYCLES=4`.
- Reset: hold `rst` for 3 edges with `sw_in=10'h3FF`. Required: all outputs 0 during reset. After release, `sw_stable=10'h3FF` exactly 6 edges later, with a single `changed` pulse and `changed_mask=10'h3FF`.
- Clean step: `sw_in` goes from 0 to `10'h300` (`ctrl`=2'b11). Required: `ctrl`=2'b11 on the 6th edge and not earlier; `changed_mask=10'h300` for one cycle.
- Bounce reject: on bit 0, drive a 1 for 3 cycles, 0 for 1 cycle, then 1 for 3 cycles, then return to 0. Required: `sw_stable[0]` stays 0 and `changed` is never asserted.
- Bounce then settle: on bit 2, drive a 1 for 2 cycles, 0 for 1 cycle, then hold 1. Required: `sw_stable[2]` rises 6 edges after the final rising sample; exactly one `changed` pulse.
- Independent bits: bit 9 changes 2 cycles before bit 1. Required: two separate `changed` pulses 2 cycles apart, with masks `10'h200` then `10'h002`.
- Reset mid-count: `sw_in=10'h0FF`, then assert `rst` on the 4th edge. Required: `sw_stable` stays 0 through reset, then settles to `10'h0FF` 6 edges after release.

Source files
------------

// File: rtl/sel_input_debounce.sv
// sel_input_debounce: synchronise and debounce ten switches feeding the 4:1 two-bit selector
//   clk          rising-edge system clock
//   rst          synchronous active-high reset
//   sw_in        raw asynchronous switch levels
//   sw_stable    settled switch levels
//   changed_mask one-cycle mask of bits that settled on the last edge
//   changed      OR of changed_mask
//   ctrl/in3..in0 selector buses sliced from sw_stable
module sel_input_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] sw_in,
    output logic [9:0] sw_stable,
    output logic [9:0] changed_mask,
    output logic       changed,
    output logic [1:0] ctrl,
    output logic [1:0] in3,
    output logic [1:0] in2,
    output logic [1:0] in1,
    output logic [1:0] in0
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    logic [9:0] s1_q, s2_q, sw_stable_q, sw_stable_d, changed_mask_q, changed_mask_d;
    logic [CW-1:0] cnt_q [10];
    logic [CW-1:0] cnt_d [10];
    always_comb begin
        sw_stable_d    = sw_stable_q;
        changed_mask_d = '0;
        for (int i = 0; i < 10; i++) begin
            cnt_d[i] = '0;
            if (s2_q[i] != sw_stable_q[i]) begin
                if (cnt_q[i] == CNT_LAST) begin
                    sw_stable_d[i]    = s2_q[i];
                    changed_mask_d[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q           <= '0;
            s2_q           <= '0;
            sw_stable_q    <= '0;
            changed_mask_q <= '0;
            for (int i = 0; i < 10; i++) cnt_q[i] <= '0;
        end else begin
            s1_q           <= sw_in;
            s2_q           <= s1_q;
            sw_stable_q    <= sw_stable_d;
            changed_mask_q <= changed_mask_d;
            for (int i = 0; i < 10; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign sw_stable    = sw_stable_q;
    assign changed_mask = changed_mask_q;
    assign changed      = |changed_mask_q;
    assign ctrl         = sw_stable_q[9:8];
    assign in3          = sw_stable_q[7:6];
    assign in2          = sw_stable_q[5:4];
    assign in1          = sw_stable_q[3:2];
    assign in0          = sw_stable_q[1:0];
endmodule
